// File: rtl/calc_pkg.sv
// Shared types and constants for the hex calculator control path.
package calc_pkg;

  localparam int unsigned OPW = 2;

  typedef logic [OPW-1:0] op_t;

  localparam op_t OP_ADD = OPW'(0);
  localparam op_t OP_SUB = OPW'(1);
  localparam op_t OP_MUL = OPW'(2);
  localparam op_t OP_DIV = OPW'(3);

  typedef enum logic [2:0] {
    S_FLOW,
    S_ENTRY,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  // One-cycle strobes toward the register bank and ALU
  typedef struct packed {
    logic v1_shift;
    logic v1_overwrite;
    logic v1_load_ans;
    logic v2_load;
    logic alu_start;
  } strobe_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad/ALU-facing handshake bundle of the calculator sequencer.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic newhex;
  logic newop;
  op_t  opcode;
  logic eq;
  logic alu_done;
  logic alu_ovf;
  logic v1_shift;
  logic v1_overwrite;
  logic v1_load_ans;
  logic v2_load;
  logic alu_start;
  op_t  alu_op;
  logic busy;
  logic err;

  modport master (
    output newhex, newop, opcode, eq, alu_done, alu_ovf,
    input  v1_shift, v1_overwrite, v1_load_ans, v2_load, alu_start, alu_op, busy, err
  );

  modport slave (
    input  newhex, newop, opcode, eq, alu_done, alu_ovf,
    output v1_shift, v1_overwrite, v1_load_ans, v2_load, alu_start, alu_op, busy, err
  );
endinterface

// File: rtl/calc_watchdog.sv
// Saturating cycle counter that flags an ALU operation overrunning its budget.
module calc_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  assign expired_c = (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired_c) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: keypad events to register strobes and ALU handshake.
// Optional operator chaining is enabled by defining CALC_CHAIN_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic             clock,
  input logic             reset,
  calc_sequencer_if.slave bus
);
  state_t  state_q, state_d;
  logic    op_valid_q, op_valid_d;
  op_t     alu_op_q, alu_op_d;
  strobe_t strb_q, strb_d;
  logic    busy_q, err_q;
  logic    wd_clear;
  logic    wd_expired_c;
`ifdef CALC_CHAIN_EN
  op_t     op_nxt_q, op_nxt_d;
  logic    chain_q, chain_d;
`endif

  calc_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear     (wd_clear),
    .enable    (state_q == S_EXEC),
    .expired_c (wd_expired_c)
  );

  // Next-state and strobe decode; eq outranks newop which outranks newhex
  always_comb begin
    state_d    = state_q;
    op_valid_d = op_valid_q;
    alu_op_d   = alu_op_q;
    strb_d     = '0;
    wd_clear   = 1'b0;
`ifdef CALC_CHAIN_EN
    op_nxt_d   = op_nxt_q;
    chain_d    = chain_q;
`endif
    case (state_q)
      S_FLOW, S_ENTRY: begin
        if (bus.eq) begin
          if (op_valid_q) begin
            strb_d.alu_start = 1'b1;
            wd_clear         = 1'b1;
            state_d          = S_EXEC;
`ifdef CALC_CHAIN_EN
            chain_d          = 1'b0;
`endif
          end else begin
            state_d = S_FLOW;
          end
        end else if (bus.newop) begin
`ifdef CALC_CHAIN_EN
          if (state_q == S_ENTRY && op_valid_q) begin
            op_nxt_d         = bus.opcode;
            chain_d          = 1'b1;
            strb_d.alu_start = 1'b1;
            wd_clear         = 1'b1;
            state_d          = S_EXEC;
          end else
`endif
          begin
            strb_d.v2_load = 1'b1;
            alu_op_d       = bus.opcode;
            op_valid_d     = 1'b1;
            state_d        = S_FLOW;
          end
        end else if (bus.newhex) begin
          if (state_q == S_FLOW) begin
            strb_d.v1_overwrite = 1'b1;
            state_d             = S_ENTRY;
          end else begin
            strb_d.v1_shift = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (bus.alu_done) begin
          strb_d.v1_load_ans = 1'b1;
          if (bus.alu_ovf) begin
            state_d = S_ERR;
          end else begin
            op_valid_d = 1'b0;
            state_d    = S_FLOW;
`ifdef CALC_CHAIN_EN
            if (chain_q) state_d = S_WB;
`endif
          end
        end else if (wd_expired_c) begin
          state_d = S_ERR;
        end
      end
`ifdef CALC_CHAIN_EN
      S_WB: begin
        strb_d.v2_load = 1'b1;
        alu_op_d       = op_nxt_q;
        op_valid_d     = 1'b1;
        chain_d        = 1'b0;
        state_d        = S_FLOW;
      end
`endif
      S_ERR: begin
        if (bus.newhex) begin
          strb_d.v1_overwrite = 1'b1;
          op_valid_d          = 1'b0;
          state_d             = S_ENTRY;
        end
      end
      default: state_d = S_FLOW;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FLOW;
      op_valid_q <= 1'b0;
      alu_op_q   <= '0;
      strb_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CALC_CHAIN_EN
      op_nxt_q   <= '0;
      chain_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_valid_q <= op_valid_d;
      alu_op_q   <= alu_op_d;
      strb_q     <= strb_d;
      busy_q     <= (state_d == S_EXEC) || (state_d == S_WB);
      err_q      <= (state_d == S_ERR);
`ifdef CALC_CHAIN_EN
      op_nxt_q   <= op_nxt_d;
      chain_q    <= chain_d;
`endif
    end
  end

  assign bus.v1_shift     = strb_q.v1_shift;
  assign bus.v1_overwrite = strb_q.v1_overwrite;
  assign bus.v1_load_ans  = strb_q.v1_load_ans;
  assign bus.v2_load      = strb_q.v2_load;
  assign bus.alu_start    = strb_q.alu_start;
  assign bus.alu_op       = alu_op_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
endmodule
